spi_master: RTL and testbench

SPI_MASTER -- requirements
Module: spi_master

---
 rtl/spi_master.sv | 145 ++++++++++++++
 tb/tb_spi_master.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// Single-clock SPI-style frame master: sends {cmd, din} MSB first and, for
// read-data frames, collects ADDR_SIZE bits from MISO after RD_LAT wait cycles.
`timescale 1ns/1ps
module spi_master #(
    parameter int unsigned ADDR_SIZE = 8,
    parameter int unsigned RD_LAT    = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [1:0]           cmd,
    input  logic [ADDR_SIZE-1:0] din,
    output logic                 busy,
    output logic                 done,
    output logic [ADDR_SIZE-1:0] rd_data,
    output logic                 rd_valid,
    output logic                 SS_n,
    output logic                 MOSI,
    input  logic                 MISO
);

    localparam int unsigned FRAME_W = ADDR_SIZE + 2;
    localparam int unsigned CNT_W   = $clog2(FRAME_W + 16);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SEL   = 3'd1,
        SHIFT = 3'd2,
        WAIT  = 3'd3,
        READ  = 3'd4,
        END   = 3'd5
    } state_t;

    state_t               r_state;
    logic [FRAME_W-1:0]   r_frame;
    logic [ADDR_SIZE-1:0] r_shift;
    logic [ADDR_SIZE-1:0] r_rd_data;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_is_rd;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_rd_valid;
    logic                 r_ss_n;
    logic                 r_mosi;
    logic [ADDR_SIZE-1:0] w_rd_byte;

    // Byte as it stands once the current MISO bit is shifted in
    assign w_rd_byte = {r_shift[ADDR_SIZE-2:0], MISO};

    // Frame FSM; every output is registered alongside the state it belongs to
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_frame    <= '0;
            r_shift    <= '0;
            r_rd_data  <= '0;
            r_cnt      <= '0;
            r_is_rd    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_rd_valid <= 1'b0;
            r_ss_n     <= 1'b1;
            r_mosi     <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_rd_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_ss_n <= 1'b1;
                    r_mosi <= 1'b0;
                    r_busy <= 1'b0;
                    if (start) begin
                        r_frame <= {cmd, din};
                        r_is_rd <= (cmd == 2'b11);
                        r_state <= SEL;
                        r_ss_n  <= 1'b0;
                        r_mosi  <= cmd[1];
                        r_busy  <= 1'b1;
                    end
                end
                SEL: begin
                    r_mosi  <= r_frame[FRAME_W-1];
                    r_frame <= r_frame << 1;
                    r_cnt   <= CNT_W'(FRAME_W - 1);
                    r_state <= SHIFT;
                end
                SHIFT: begin
                    if (r_cnt == '0) begin
                        r_mosi <= 1'b0;
                        if (r_is_rd) begin
                            r_cnt   <= CNT_W'(RD_LAT - 1);
                            r_state <= WAIT;
                        end else begin
                            r_ss_n  <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= END;
                        end
                    end else begin
                        r_mosi  <= r_frame[FRAME_W-1];
                        r_frame <= r_frame << 1;
                        r_cnt   <= r_cnt - 1'b1;
                    end
                end
                WAIT: begin
                    if (r_cnt == '0) begin
                        r_cnt   <= CNT_W'(ADDR_SIZE - 1);
                        r_state <= READ;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                READ: begin
                    r_shift <= w_rd_byte;
                    if (r_cnt == '0) begin
                        r_rd_data  <= w_rd_byte;
                        r_rd_valid <= 1'b1;
                        r_ss_n     <= 1'b1;
                        r_done     <= 1'b1;
                        r_state    <= END;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                END: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_ss_n  <= 1'b1;
                    r_mosi  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
    assign SS_n     = r_ss_n;
    assign MOSI     = r_mosi;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: write, read, hold, ignored start,
// mid-frame reset and back-to-back frames, with a simple receiving slave.
`timescale 1ns/1ps
module tb_spi_master;

    localparam int unsigned AW = 8;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [1:0]    cmd;
    logic [AW-1:0] din;
    logic          busy;
    logic          done;
    logic [AW-1:0] rd_data;
    logic          rd_valid;
    logic          SS_n;
    logic          MOSI;
    logic          MISO;

    int n_checks = 0;
    int n_fail   = 0;

    logic [10:0] rx_sr;
    logic [10:0] rx_last;
    int          rx_bits;
    logic        rx_valid;
    int          rx_count = 0;

    spi_master #(.ADDR_SIZE(AW), .RD_LAT(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .cmd      (cmd),
        .din      (din),
        .busy     (busy),
        .done     (done),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .MISO     (MISO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave: collects MOSI while selected, pulses rx_valid once deselected
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sr    <= '0;
            rx_bits  <= 0;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (!SS_n) begin
                rx_sr   <= {rx_sr[9:0], MOSI};
                rx_bits <= rx_bits + 1;
            end else if (rx_bits != 0) begin
                rx_valid <= 1'b1;
                rx_last  <= rx_sr;
                rx_bits  <= 0;
            end
        end
    end

    always @(posedge clk) if (rx_valid) rx_count <= rx_count + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; start = 1'b0; cmd = 2'b00; din = '0; MISO = 1'b0;
        #1 rst_n = 1'b0;
        step(); step();
        n_checks++; if (SS_n !== 1'b1) begin n_fail++; $display("FAIL rst_ss_n got %b exp 1", SS_n); end
        n_checks++; if (MOSI !== 1'b0) begin n_fail++; $display("FAIL rst_mosi got %b exp 0", MOSI); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b exp 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done got %b exp 0", done); end
        n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rd_valid got %b exp 0", rd_valid); end
        n_checks++; if (rd_data !== 8'h00) begin n_fail++; $display("FAIL rst_rd_data got %h exp 00", rd_data); end
        rst_n = 1'b1;
        step(); step();
    endtask

    task automatic test_write_addr();
        logic [10:0] exp_mosi;
        logic exp_m;
        exp_mosi = 11'b000_1010_0101;
        cmd = 2'b00; din = 8'hA5; start = 1'b1;
        step();
        start = 1'b0; cmd = 2'b11; din = 8'h00;
        for (int c = 1; c <= 13; c++) begin
            if (c > 1) step();
            exp_m = (c <= 11) ? exp_mosi[11-c] : 1'b0;
            n_checks++; if (SS_n !== (c > 11)) begin n_fail++; $display("FAIL wa_ss_n c=%0d got %b exp %b", c, SS_n, c > 11); end
            n_checks++; if (MOSI !== exp_m) begin n_fail++; $display("FAIL wa_mosi c=%0d got %b exp %b", c, MOSI, exp_m); end
            n_checks++; if (done !== (c == 12)) begin n_fail++; $display("FAIL wa_done c=%0d got %b exp %b", c, done, c == 12); end
            n_checks++; if (busy !== (c <= 12)) begin n_fail++; $display("FAIL wa_busy c=%0d got %b exp %b", c, busy, c <= 12); end
            n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL wa_rd_valid c=%0d got %b exp 0", c, rd_valid); end
        end
    endtask

    task automatic test_read_data();
        logic [10:0] exp_mosi;
        logic [7:0]  miso_byte;
        logic exp_m;
        exp_mosi  = 11'b111_0000_0000;
        miso_byte = 8'h3C;
        cmd = 2'b11; din = 8'h00; start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 23; c++) begin
            if (c > 1) step();
            exp_m = (c <= 11) ? exp_mosi[11-c] : 1'b0;
            n_checks++; if (SS_n !== (c > 21)) begin n_fail++; $display("FAIL rd_ss_n c=%0d got %b exp %b", c, SS_n, c > 21); end
            n_checks++; if (MOSI !== exp_m) begin n_fail++; $display("FAIL rd_mosi c=%0d got %b exp %b", c, MOSI, exp_m); end
            n_checks++; if (done !== (c == 22)) begin n_fail++; $display("FAIL rd_done c=%0d got %b exp %b", c, done, c == 22); end
            n_checks++; if (rd_valid !== (c == 22)) begin n_fail++; $display("FAIL rd_rd_valid c=%0d got %b exp %b", c, rd_valid, c == 22); end
            n_checks++; if (busy !== (c <= 22)) begin n_fail++; $display("FAIL rd_busy c=%0d got %b exp %b", c, busy, c <= 22); end
            if (c == 21) begin
                n_checks++; if (rd_data !== 8'h00) begin n_fail++; $display("FAIL rd_data_before got %h exp 00", rd_data); end
            end
            if (c >= 22) begin
                n_checks++; if (rd_data !== 8'h3C) begin n_fail++; $display("FAIL rd_data c=%0d got %h exp 3c", c, rd_data); end
            end
            MISO = (c >= 14 && c <= 21) ? miso_byte[21-c] : 1'b0;
        end
    endtask

    task automatic test_rd_hold();
        logic [10:0] exp_mosi;
        logic exp_m;
        exp_mosi = 11'b001_1111_1111;
        cmd = 2'b01; din = 8'hFF; start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 13; c++) begin
            if (c > 1) step();
            exp_m = (c <= 11) ? exp_mosi[11-c] : 1'b0;
            n_checks++; if (MOSI !== exp_m) begin n_fail++; $display("FAIL wd_mosi c=%0d got %b exp %b", c, MOSI, exp_m); end
            n_checks++; if (done !== (c == 12)) begin n_fail++; $display("FAIL wd_done c=%0d got %b exp %b", c, done, c == 12); end
            n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL wd_rd_valid c=%0d got %b exp 0", c, rd_valid); end
            n_checks++; if (rd_data !== 8'h3C) begin n_fail++; $display("FAIL wd_rd_hold c=%0d got %h exp 3c", c, rd_data); end
        end
    endtask

    task automatic test_start_ignored();
        int n_done;
        n_done = 0;
        cmd = 2'b00; din = 8'h5A; start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (c > 1) step();
            if (done) n_done++;
            n_checks++; if (SS_n !== (c > 11)) begin n_fail++; $display("FAIL ign_ss_n c=%0d got %b exp %b", c, SS_n, c > 11); end
            if (c == 5) start = 1'b1;
            if (c == 6) start = 1'b0;
        end
        n_checks++; if (n_done !== 1) begin n_fail++; $display("FAIL ign_done_count got %0d exp 1", n_done); end
    endtask

    task automatic test_reset_mid();
        logic [10:0] exp_mosi;
        logic exp_m;
        cmd = 2'b11; din = 8'h00; start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 2; c <= 5; c++) step();
        rst_n = 1'b0;
        #1;
        n_checks++; if (SS_n !== 1'b1) begin n_fail++; $display("FAIL mid_rst_ss_n got %b exp 1", SS_n); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy got %b exp 0", busy); end
        for (int c = 0; c < 3; c++) begin
            step();
            n_checks++; if (done !== 1'b0 || rd_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_pulse got done=%b rd_valid=%b exp 0 0", done, rd_valid); end
        end
        rst_n = 1'b1;
        step();
        n_checks++; if (rd_data !== 8'h00) begin n_fail++; $display("FAIL mid_rst_rd_data got %h exp 00", rd_data); end
        exp_mosi = 11'b110_0011_1100;
        cmd = 2'b10; din = 8'h3C; start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 13; c++) begin
            if (c > 1) step();
            exp_m = (c <= 11) ? exp_mosi[11-c] : 1'b0;
            n_checks++; if (SS_n !== (c > 11)) begin n_fail++; $display("FAIL ra_ss_n c=%0d got %b exp %b", c, SS_n, c > 11); end
            n_checks++; if (MOSI !== exp_m) begin n_fail++; $display("FAIL ra_mosi c=%0d got %b exp %b", c, MOSI, exp_m); end
            n_checks++; if (done !== (c == 12)) begin n_fail++; $display("FAIL ra_done c=%0d got %b exp %b", c, done, c == 12); end
            n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL ra_rd_valid c=%0d got %b exp 0", c, rd_valid); end
        end
    endtask

    task automatic test_back_to_back();
        int n_done;
        int rx_base;
        int m;
        logic exp_ss;
        n_done  = 0;
        rx_base = rx_count;
        cmd = 2'b01; din = 8'h11; start = 1'b1;
        for (int c = 1; c <= 45; c++) begin
            step();
            m = c % 13;
            exp_ss = (c > 38) ? 1'b1 : ((m == 0 || m == 12) ? 1'b1 : 1'b0);
            if (done) n_done++;
            n_checks++; if (SS_n !== exp_ss) begin n_fail++; $display("FAIL b2b_ss_n c=%0d got %b exp %b", c, SS_n, exp_ss); end
            n_checks++; if (done !== (c <= 38 && m == 12)) begin n_fail++; $display("FAIL b2b_done c=%0d got %b exp %b", c, done, c <= 38 && m == 12); end
            if (c == 27) start = 1'b0;
        end
        n_checks++; if (n_done !== 3) begin n_fail++; $display("FAIL b2b_done_count got %0d exp 3", n_done); end
        n_checks++; if (rx_count - rx_base !== 3) begin n_fail++; $display("FAIL b2b_rx_valid_count got %0d exp 3", rx_count - rx_base); end
        n_checks++; if (rx_last[9:0] !== 10'b01_0001_0001) begin n_fail++; $display("FAIL b2b_rx_frame got %b exp 0100010001", rx_last[9:0]); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout got running exp finished");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_addr();
        step();
        test_read_data();
        step();
        test_rd_hold();
        step();
        test_start_ignored();
        step();
        test_reset_mid();
        step();
        test_back_to_back();
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
